// File: rtl/poly_tone_generator.sv
// Polyphonic tone generator: NUM_VOICES phase accumulators time-share one registered
// sine table, each voice shaped by its own attack/sustain/release envelope.
module poly_tone_generator #(
    parameter int NUM_VOICES   = 4,
    parameter int PHASE_W      = 32,
    parameter int ENV_W        = 8,
    parameter int OUT_W        = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          step_in,
    input  logic [NUM_VOICES-1:0]         gate_in,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_incr_in,
    output logic [OUT_W-1:0]              sample_out,
    output logic                          sample_valid_out,
    output logic                          busy_out,
    output logic                          overrun_out,
    output logic [NUM_VOICES-1:0]         active_out
);

    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W   = $clog2(NUM_VOICES + 4);
    localparam int ACC_W   = OUT_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W  = 8 + ENV_W + 1;
    localparam logic [ENV_W-1:0]        ENV_MAX = {ENV_W{1'b1}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_ATTACK  = 2'd1,
        V_SUSTAIN = 2'd2,
        V_RELEASE = 2'd3
    } voice_state_e;

    // Classic unsigned 0..255 sine table; the signed sample is this with the MSB flipped.
    function automatic logic [7:0] sine_lut(input logic [5:0] idx);
        case (idx)
            6'd0:  sine_lut = 8'd128;  6'd1:  sine_lut = 8'd140;  6'd2:  sine_lut = 8'd152;  6'd3:  sine_lut = 8'd165;
            6'd4:  sine_lut = 8'd176;  6'd5:  sine_lut = 8'd188;  6'd6:  sine_lut = 8'd198;  6'd7:  sine_lut = 8'd208;
            6'd8:  sine_lut = 8'd218;  6'd9:  sine_lut = 8'd226;  6'd10: sine_lut = 8'd234;  6'd11: sine_lut = 8'd240;
            6'd12: sine_lut = 8'd245;  6'd13: sine_lut = 8'd250;  6'd14: sine_lut = 8'd253;  6'd15: sine_lut = 8'd254;
            6'd16: sine_lut = 8'd255;  6'd17: sine_lut = 8'd254;  6'd18: sine_lut = 8'd253;  6'd19: sine_lut = 8'd250;
            6'd20: sine_lut = 8'd245;  6'd21: sine_lut = 8'd240;  6'd22: sine_lut = 8'd234;  6'd23: sine_lut = 8'd226;
            6'd24: sine_lut = 8'd218;  6'd25: sine_lut = 8'd208;  6'd26: sine_lut = 8'd198;  6'd27: sine_lut = 8'd188;
            6'd28: sine_lut = 8'd176;  6'd29: sine_lut = 8'd165;  6'd30: sine_lut = 8'd152;  6'd31: sine_lut = 8'd140;
            6'd32: sine_lut = 8'd128;  6'd33: sine_lut = 8'd115;  6'd34: sine_lut = 8'd103;  6'd35: sine_lut = 8'd90;
            6'd36: sine_lut = 8'd79;   6'd37: sine_lut = 8'd67;   6'd38: sine_lut = 8'd57;   6'd39: sine_lut = 8'd47;
            6'd40: sine_lut = 8'd37;   6'd41: sine_lut = 8'd29;   6'd42: sine_lut = 8'd21;   6'd43: sine_lut = 8'd15;
            6'd44: sine_lut = 8'd10;   6'd45: sine_lut = 8'd5;    6'd46: sine_lut = 8'd2;    6'd47: sine_lut = 8'd1;
            6'd48: sine_lut = 8'd0;    6'd49: sine_lut = 8'd1;    6'd50: sine_lut = 8'd2;    6'd51: sine_lut = 8'd5;
            6'd52: sine_lut = 8'd10;   6'd53: sine_lut = 8'd15;   6'd54: sine_lut = 8'd21;   6'd55: sine_lut = 8'd29;
            6'd56: sine_lut = 8'd37;   6'd57: sine_lut = 8'd47;   6'd58: sine_lut = 8'd57;   6'd59: sine_lut = 8'd67;
            6'd60: sine_lut = 8'd79;   6'd61: sine_lut = 8'd90;   6'd62: sine_lut = 8'd103;  6'd63: sine_lut = 8'd115;
            default: sine_lut = 8'd128;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[OUT_W-1:0];
    endfunction

    seq_state_e                seq_r, seq_n_s;
    logic [CNT_W-1:0]          cnt_r;
    logic                      busy_r, valid_r, overrun_r;
    logic [OUT_W-1:0]          sample_r;
    logic                      accept_s, slot_vld_s, sample_done_s;
    logic [VOICE_W-1:0]        slot_idx_s;

    logic [PHASE_W-1:0]        phase_r [NUM_VOICES];
    logic [ENV_W-1:0]          env_r   [NUM_VOICES];
    voice_state_e              vstate_r[NUM_VOICES];
    logic [NUM_VOICES-1:0]     active_r;

    logic [PHASE_W-1:0]        cur_phase_s, cur_incr_s, nxt_phase_s;
    logic [ENV_W-1:0]          cur_env_s, nxt_env_s;
    logic [ENV_W:0]            env_sum_s;
    voice_state_e              cur_state_s, nxt_state_s;
    logic                      cur_gate_s;

    logic signed [7:0]         lut_r;
    logic [ENV_W-1:0]          env_d_r;
    logic                      lut_vld_r, prod_vld_r;
    logic signed [ENV_W:0]     env_ext_s;
    logic signed [PROD_W-1:0]  prod_full_s;
    logic signed [8:0]         prod_r;
    logic signed [ACC_W-1:0]   acc_r;

    assign accept_s      = (seq_r == SEQ_IDLE) && step_in;
    assign slot_vld_s    = (seq_r == SEQ_RUN);
    assign slot_idx_s    = cnt_r[VOICE_W-1:0];
    assign sample_done_s = (seq_r == SEQ_DRAIN) && (cnt_r == CNT_W'(NUM_VOICES + 2));

    // Sequencer next state: RUN walks the voice slots, DRAIN flushes the pipeline.
    always_comb begin
        seq_n_s = seq_r;
        case (seq_r)
            SEQ_IDLE: begin
                if (step_in) seq_n_s = SEQ_RUN;
                else         seq_n_s = SEQ_IDLE;
            end
            SEQ_RUN: begin
                if (cnt_r == CNT_W'(NUM_VOICES - 1)) seq_n_s = SEQ_DRAIN;
                else                                 seq_n_s = SEQ_RUN;
            end
            SEQ_DRAIN: begin
                if (cnt_r == CNT_W'(NUM_VOICES + 3)) seq_n_s = SEQ_IDLE;
                else                                 seq_n_s = SEQ_DRAIN;
            end
            default: seq_n_s = SEQ_IDLE;
        endcase
    end

    // Sequencer state, slot counter and busy flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            seq_r  <= SEQ_IDLE;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else begin
            seq_r  <= seq_n_s;
            busy_r <= (seq_n_s != SEQ_IDLE);
            cnt_r  <= (seq_r == SEQ_IDLE || seq_n_s == SEQ_IDLE) ? '0 : cnt_r + CNT_W'(1);
        end
    end

    // Next phase/envelope/state for the voice owning the current slot.
    always_comb begin
        cur_phase_s = phase_r[slot_idx_s];
        cur_env_s   = env_r[slot_idx_s];
        cur_state_s = vstate_r[slot_idx_s];
        cur_gate_s  = gate_in[slot_idx_s];
        cur_incr_s  = phase_incr_in[int'(slot_idx_s) * PHASE_W +: PHASE_W];
        env_sum_s   = {1'b0, cur_env_s} + (ENV_W + 1)'(ATTACK_STEP);
        nxt_env_s   = cur_env_s;
        nxt_state_s = cur_state_s;
        if (cur_state_s != V_IDLE) begin
            nxt_phase_s = cur_phase_s + cur_incr_s;
        end else begin
            nxt_phase_s = cur_phase_s;
        end
        case (cur_state_s)
            V_IDLE: begin
                nxt_env_s   = '0;
                nxt_phase_s = '0;
                if (cur_gate_s) nxt_state_s = V_ATTACK;
                else            nxt_state_s = V_IDLE;
            end
            V_ATTACK: begin
                if (!cur_gate_s) begin
                    nxt_state_s = V_RELEASE;
                end else if (env_sum_s >= {1'b0, ENV_MAX}) begin
                    nxt_env_s   = ENV_MAX;
                    nxt_state_s = V_SUSTAIN;
                end else begin
                    nxt_env_s = env_sum_s[ENV_W-1:0];
                end
            end
            V_SUSTAIN: begin
                nxt_env_s = ENV_MAX;
                if (!cur_gate_s) nxt_state_s = V_RELEASE;
                else             nxt_state_s = V_SUSTAIN;
            end
            V_RELEASE: begin
                // A retrigger resumes attack from the current level without touching phase.
                if (cur_gate_s) begin
                    nxt_state_s = V_ATTACK;
                end else if ({1'b0, cur_env_s} <= (ENV_W + 1)'(RELEASE_STEP)) begin
                    nxt_env_s   = '0;
                    nxt_phase_s = '0;
                    nxt_state_s = V_IDLE;
                end else begin
                    nxt_env_s = cur_env_s - ENV_W'(RELEASE_STEP);
                end
            end
            default: begin
                nxt_env_s   = '0;
                nxt_phase_s = '0;
                nxt_state_s = V_IDLE;
            end
        endcase
    end

    // Per-voice state write-back in the voice's slot.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_r[v]  <= '0;
                env_r[v]    <= '0;
                vstate_r[v] <= V_IDLE;
            end
            active_r <= '0;
        end else if (slot_vld_s) begin
            phase_r[slot_idx_s]  <= nxt_phase_s;
            env_r[slot_idx_s]    <= nxt_env_s;
            vstate_r[slot_idx_s] <= nxt_state_s;
            active_r[slot_idx_s] <= (nxt_state_s != V_IDLE);
        end
    end

    assign env_ext_s   = {1'b0, env_d_r};
    assign prod_full_s = PROD_W'(lut_r) * PROD_W'(env_ext_s);

    // Table read, scaling and accumulation pipeline, all from pre-update voice values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lut_r      <= '0;
            env_d_r    <= '0;
            lut_vld_r  <= 1'b0;
            prod_r     <= '0;
            prod_vld_r <= 1'b0;
            acc_r      <= '0;
        end else begin
            lut_r      <= sine_lut(cur_phase_s[PHASE_W-1 -: 6]) ^ 8'h80;
            env_d_r    <= cur_env_s;
            lut_vld_r  <= slot_vld_s;
            prod_r     <= 9'(prod_full_s >>> ENV_W);
            prod_vld_r <= lut_vld_r;
            if (accept_s) begin
                acc_r <= '0;
            end else if (prod_vld_r) begin
                acc_r <= acc_r + ACC_W'(prod_r);
            end
        end
    end

    // Output sample, valid strobe and sticky overrun flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sample_r  <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= sample_done_s;
            overrun_r <= overrun_r | (step_in & busy_r);
            if (sample_done_s) begin
                sample_r <= saturate(acc_r);
            end
        end
    end

    assign sample_out       = sample_r;
    assign sample_valid_out = valid_r;
    assign busy_out         = busy_r;
    assign overrun_out      = overrun_r;
    assign active_out       = active_r;

endmodule
